// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    localparam logic [3:0] COL_RESET = 4'b0001;

    // True when exactly one of the four bits is set.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    // Next column in the scan order; 4'b1000 wraps back to 4'b0001.
    function automatic logic [3:0] next_col(input logic [3:0] col);
        return {col[2:0], col[3]};
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for a bundle of independent asynchronous inputs.
// Each bit is synchronized on its own; multi-bit coherence is not needed
// because the scanner requires the rows to stay stable for many cycles.
module keypad_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Shift the raw input through two flops to settle metastability.
    // NOTE: non-blocking assignments keep this a two-stage shift; blocking
    // would let din fall straight through to sync_q in a single edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scan controller.
// Drives one column at a time, samples the synchronized rows at the end of
// each column dwell, debounces a single-key press, freezes the scan while the
// key is held and debounces its release. One key_valid strobe per press.
// Optional build macro KEYPAD_REPEAT_EN: while a key stays held, key_valid
// re-pulses every REPEAT_CYC cycles (key_row/key_col unchanged).
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int REPEAT_CYC   = 500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int CNT_MAX_A = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_CYC) ? CNT_MAX_A : REPEAT_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

    logic [3:0] row_s;

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       col_q, col_d;
    logic [3:0]       cand_row_q, cand_row_d;
    logic [3:0]       cand_col_q, cand_col_d;
    logic [3:0]       key_row_q, key_row_d;
    logic [3:0]       key_col_q, key_col_d;
    logic             key_valid_q, key_valid_d;
    logic             key_pressed_q, key_pressed_d;
`ifdef KEYPAD_REPEAT_EN
    logic [CNT_W-1:0] rep_q, rep_d;
`endif

    keypad_sync #(.W(4)) u_row_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (row_in),
        .dout    (row_s)
    );

    // Scan / debounce / hold / release sequencing and output next-state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        cand_row_d  = cand_row_q;
        cand_col_d  = cand_col_q;
        key_row_d   = key_row_q;
        key_col_d   = key_col_q;
        key_valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d       = '0;
`endif

        case (state_q)
            SCAN: begin
                // Rows are only trusted on the last dwell cycle, after the
                // column switch and the synchronizer have both settled.
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (is_onehot4(row_s)) begin
                        cand_row_d = row_s;
                        cand_col_d = col_q;
                        state_d    = DEBOUNCE;
                    end else begin
                        col_d = next_col(col_q);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            DEBOUNCE: begin
                if (row_s != cand_row_q) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    col_d   = next_col(col_q);
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    key_row_d   = cand_row_q;
                    key_col_d   = cand_col_q;
                    key_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            HELD: begin
                // Only the captured row matters; extra keys are ignored.
                if ((row_s & cand_row_q) == 4'b0000) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (rep_q == REP_LAST) begin
                    key_valid_d = 1'b1;
                    rep_d       = '0;
                end else begin
                    rep_d = rep_q + CNT_ONE;
                end
`endif
            end

            RELEASE: begin
                if ((row_s & cand_row_q) != 4'b0000) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    col_d   = next_col(col_q);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = SCAN;
                cnt_d   = '0;
                col_d   = COL_RESET;
            end
        endcase

        key_pressed_d = (state_d == HELD) || (state_d == RELEASE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= SCAN;
            cnt_q         <= '0;
            col_q         <= COL_RESET;
            cand_row_q    <= '0;
            cand_col_q    <= '0;
            key_row_q     <= '0;
            key_col_q     <= '0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            col_q         <= col_d;
            cand_row_q    <= cand_row_d;
            cand_col_q    <= cand_col_d;
            key_row_q     <= key_row_d;
            key_col_q     <= key_col_d;
            key_valid_q   <= key_valid_d;
            key_pressed_q <= key_pressed_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q         <= rep_d;
`endif
        end
    end

    assign col_out     = col_q;
    assign key_row     = key_row_q;
    assign key_col     = key_col_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl: a 4x4 keypad matrix model drives row_in
// from the column drive, and a behavioural reference model is compared
// against every DUT output on every cycle.
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int REP      = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic       key_valid;
    logic       key_pressed;

    // pressed[r*4+c] = key at row r, column c is physically down.
    logic [15:0] pressed = '0;

    int checks = 0;
    int errors = 0;
    int n_strobes = 0;
    int n_falls = 0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CYC (DEB),
        .REPEAT_CYC   (REP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_row     (key_row),
        .key_col     (key_col),
        .key_valid   (key_valid),
        .key_pressed (key_pressed)
    );

    // A row line reads high when any pressed key on it sits in a driven column.
    function automatic logic [3:0] keypad(input logic [15:0] p, input logic [3:0] col);
        logic [3:0] r;
        r = '0;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (p[rr*4+cc] && col[cc]) r[rr] = 1'b1;
        return r;
    endfunction

    assign row_in = keypad(pressed, col_out);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {P_SCAN, P_DEB, P_HELD, P_REL} phase_t;
    phase_t     m_phase;
    int         m_col;      // index of the driven column, 0..3
    int         m_ccol;     // index of the captured column
    int         m_cnt;      // cycles elapsed in the current phase
    int         m_rep;      // cycles held since last (re)strobe
    logic [3:0] m_s1, m_s2; // synchronizer history
    logic [3:0] m_cand, m_krow, m_kcol;
    bit         m_valid;

    task automatic model_reset();
        m_phase = P_SCAN;
        m_col = 0; m_ccol = 0; m_cnt = 0; m_rep = 0;
        m_s1 = '0; m_s2 = '0;
        m_cand = '0; m_krow = '0; m_kcol = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] rs;
        logic [3:0] drive;
        rs = m_s2;
        drive = 4'b0001 << m_col;
        m_s2 = m_s1;
        m_s1 = keypad(pressed, drive);
        m_valid = 1'b0;
        case (m_phase)
            P_SCAN: begin
                m_cnt++;
                if (m_cnt == SCAN_DIV) begin
                    m_cnt = 0;
                    if ($countones(rs) == 1) begin
                        m_cand = rs; m_ccol = m_col; m_phase = P_DEB;
                    end else begin
                        m_col = (m_col + 1) % 4;
                    end
                end
            end
            P_DEB: begin
                if (rs != m_cand) begin
                    m_phase = P_SCAN; m_cnt = 0; m_col = (m_col + 1) % 4;
                end else begin
                    m_cnt++;
                    if (m_cnt == DEB) begin
                        m_phase = P_HELD; m_cnt = 0; m_rep = 0;
                        m_krow = m_cand; m_kcol = 4'b0001 << m_ccol;
                        m_valid = 1'b1;
                    end
                end
            end
            P_HELD: begin
                if ((rs & m_cand) == 4'b0000) begin
                    m_phase = P_REL; m_cnt = 0;
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    m_rep++;
                    if (m_rep == REP) begin
                        m_valid = 1'b1; m_rep = 0;
                    end
`endif
                end
            end
            P_REL: begin
                if ((rs & m_cand) != 4'b0000) begin
                    m_phase = P_HELD; m_cnt = 0; m_rep = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == DEB) begin
                        m_phase = P_SCAN; m_cnt = 0; m_col = (m_col + 1) % 4;
                    end
                end
            end
            default: model_reset();
        endcase
    endtask

    // Per-cycle comparison of every DUT output against the model.
    initial begin : compare
        logic [3:0] exp_col;
        logic       prev_kp;
        prev_kp = 1'b0;
        model_reset();
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) model_reset();
            else model_step();
            exp_col = 4'b0001 << m_col;
            check("col_out", col_out, exp_col);
            check("key_row", key_row, m_krow);
            check("key_col", key_col, m_kcol);
            check("key_valid", key_valid, m_valid);
            check("key_pressed", key_pressed, (m_phase == P_HELD) || (m_phase == P_REL));
            if (key_valid === 1'b1) n_strobes++;
            if (prev_kp && !key_pressed) n_falls++;
            prev_kp = key_pressed;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_reset_values(input string tag);
        check({tag, " col_out"}, col_out, 4'b0001);
        check({tag, " key_row"}, key_row, 4'b0000);
        check({tag, " key_col"}, key_col, 4'b0000);
        check({tag, " key_valid"}, key_valid, 1'b0);
        check({tag, " key_pressed"}, key_pressed, 1'b0);
    endtask

    task automatic do_reset(input int cycles, input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_values(tag);
        repeat (cycles) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_strobe(input string name, input int budget);
        bit found;
        int n;
        found = 1'b0;
        n = 0;
        while (!found && n < budget) begin
            @(posedge clk);
            #2;
            if (key_valid === 1'b1) found = 1'b1;
            n++;
        end
        check(name, found, 1'b1);
    endtask

    // Returns 2 ns after the edge on which col_out switched to target.
    task automatic wait_col_enter(input logic [3:0] target, input string name, input int budget);
        bit found;
        int n;
        logic [3:0] prev;
        found = 1'b0;
        n = 0;
        prev = col_out;
        while (!found && n < budget) begin
            @(posedge clk);
            #2;
            if (col_out == target && prev != target) found = 1'b1;
            prev = col_out;
            n++;
        end
        check(name, found, 1'b1);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin : stim
        int s0;
        int f0;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        reset_n = 1'b1;

        // Idle scan: column advances every SCAN_DIV cycles and wraps.
        s0 = n_strobes;
        repeat (4) @(posedge clk);
        #2;
        check("idle col after 4", col_out, 4'b0010);
        repeat (12) @(posedge clk);
        #2;
        check("idle col wrap after 16", col_out, 4'b0001);
        repeat (16) @(posedge clk);
        check("idle no strobe", n_strobes - s0, 0);

        // Single press at row 2 / column 1.
        pressed[2*4+1] = 1'b1;
        wait_strobe("press strobe", 60);
        check("press key_row", key_row, 4'b0100);
        check("press key_col", key_col, 4'b0010);
        check("press key_pressed", key_pressed, 1'b1);
        s0 = n_strobes;
        repeat (40) @(negedge clk);
`ifdef KEYPAD_REPEAT_EN
        check("hold strobes", n_strobes - s0, 2);
`else
        check("hold strobes", n_strobes - s0, 0);
`endif
        check("hold col frozen", col_out, 4'b0010);
        pressed = '0;
        repeat (20) @(negedge clk);
        check("release key_pressed", key_pressed, 1'b0);
        check("release key_row kept", key_row, 4'b0100);

        // Glitch: row 0 / col 0 held for only 5 cycles after capture.
        s0 = n_strobes;
        wait_col_enter(4'b0001, "glitch col0 reached", 40);
        pressed[0] = 1'b1;
        repeat (9) @(posedge clk);
        #2;
        pressed[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("glitch scan resumes", col_out, 4'b0010);
        check("glitch no strobe", n_strobes - s0, 0);
        check("glitch key_row kept", key_row, 4'b0100);

        // Release bounce: toggles every 3 cycles, then clean release.
        pressed[2*4+1] = 1'b1;
        wait_strobe("bounce press strobe", 60);
        s0 = n_strobes;
        f0 = n_falls;
        for (int i = 0; i < 10; i++) begin
            pressed[2*4+1] = (i % 2 == 1);
            repeat (3) @(negedge clk);
        end
        pressed = '0;
        repeat (16) @(negedge clk);
        check("bounce no second strobe", n_strobes - s0, 0);
        check("bounce single fall", n_falls - f0, 1);
        check("bounce key_pressed low", key_pressed, 1'b0);
        wait_col_enter(4'b0001, "bounce scan resumes", 20);

        // Two keys in one column: never captured, scan keeps moving.
        s0 = n_strobes;
        pressed[1*4+2] = 1'b1;
        pressed[2*4+2] = 1'b1;
        wait_col_enter(4'b0100, "two-key col reached", 40);
        wait_col_enter(4'b1000, "two-key col advances", 8);
        repeat (30) @(negedge clk);
        check("two-key no strobe", n_strobes - s0, 0);
        pressed = '0;
        repeat (4) @(negedge clk);

        // Second key added while held is ignored.
        pressed[3*4+3] = 1'b1;
        wait_strobe("held press strobe", 60);
        check("held key_row", key_row, 4'b1000);
        check("held key_col", key_col, 4'b1000);
        pressed[0*4+3] = 1'b1;
        s0 = n_strobes;
        repeat (15) @(negedge clk);
`ifndef KEYPAD_REPEAT_EN
        check("second key no strobe", n_strobes - s0, 0);
`endif
        check("second key key_row kept", key_row, 4'b1000);
        check("second key still pressed", key_pressed, 1'b1);
        pressed = '0;
        repeat (20) @(negedge clk);

        // Reset during DEBOUNCE.
        pressed[0*4+1] = 1'b1;
        wait_col_enter(4'b0010, "deb col reached", 40);
        repeat (4) @(posedge clk);
        #2;
        do_reset(3, "rst in debounce");
        pressed = '0;
        s0 = n_strobes;
        repeat (30) @(negedge clk);
        check("after deb reset no strobe", n_strobes - s0, 0);
        check("after deb reset key_row", key_row, 4'b0000);

        // Reset during HELD with the key kept down; it is then re-accepted.
        pressed[0*4+1] = 1'b1;
        wait_strobe("pre-reset strobe", 60);
        repeat (5) @(negedge clk);
        do_reset(2, "rst in held");
        wait_strobe("re-accept after reset", 60);
        check("re-accept key_col", key_col, 4'b0010);

`ifdef KEYPAD_REPEAT_EN
        s0 = n_strobes;
        repeat (61) @(negedge clk);
        check("repeat strobes in 60", n_strobes - s0, 3);
`endif
        pressed = '0;
        repeat (20) @(negedge clk);

        // Randomized presses, multi-key presses, bounces and resets.
        for (int it = 0; it < 150; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                do_reset($urandom_range(1, 3), "rand reset");
            end else if (kind <= 2) begin
                pressed[$urandom_range(0, 15)] = 1'b1;
                pressed[$urandom_range(0, 15)] = 1'b1;
            end else begin
                pressed[$urandom_range(0, 3)*4 + $urandom_range(0, 3)] = 1'b1;
            end
            repeat ($urandom_range(1, 40)) @(negedge clk);
            pressed = '0;
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
